// File: rtl/dma_rd_beat_gen_if.sv
// Descriptor, raw read-beat and shifter-facing output bundle for dma_rd_beat_gen.
// slave is the beat generator's view, master the driving/consuming environment.
interface dma_rd_beat_gen_if #(
   parameter int DIN_WIDTH = 256,
   parameter int LEN_W     = 16,
   parameter int DIN_BCNT  = $clog2(DIN_WIDTH/8) + 1
);
   logic                 desc_vld;
   logic                 desc_rdy;
   logic [1:0]           desc_off;
   logic [LEN_W-1:0]     desc_len;

   logic [DIN_WIDTH-1:0] rd_data;
   logic                 rd_vld;
   logic                 rd_rdy;

   logic [DIN_WIDTH-1:0] out_data;
   logic [1:0]           out_sbcnt_hdr;
   logic [DIN_BCNT-1:0]  out_bcnt;
   logic                 out_eop;
   logic                 out_vld;
   logic                 out_rdy;

   modport slave (
      input  desc_vld, desc_off, desc_len, rd_data, rd_vld, out_rdy,
      output desc_rdy, rd_rdy, out_data, out_sbcnt_hdr, out_bcnt, out_eop, out_vld
   );

   modport master (
      output desc_vld, desc_off, desc_len, rd_data, rd_vld, out_rdy,
      input  desc_rdy, rd_rdy, out_data, out_sbcnt_hdr, out_bcnt, out_eop, out_vld
   );
endinterface

// File: rtl/dma_rd_beat_gen.sv
// Tags raw DMA read beats with header shift, byte count and eop for the realigning shifter.
// Optional stray-beat detection in IDLE is enabled by defining BEAT_GEN_STRAY_CHK_EN.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   S_IDLE  | no packet active, descriptor accepted here
//   S_FIRST | descriptor latched, waiting for the first raw beat
//   S_BODY  | first beat sent, remaining beats of the packet
module dma_rd_beat_gen #(
   parameter int DIN_WIDTH = 256,
   parameter int LEN_W     = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   dma_rd_beat_gen_if.slave    bus,
   output logic                err_zero_len
`ifdef BEAT_GEN_STRAY_CHK_EN
   ,
   output logic                err_stray_beat
`endif
);
   localparam int DIN_BCNT = $clog2(DIN_WIDTH/8) + 1;
   localparam logic [LEN_W:0] BYTES_W = (LEN_W+1)'(DIN_WIDTH/8);

   typedef enum logic [1:0] {S_IDLE, S_FIRST, S_BODY} state_t;

   state_t               state_q, state_d;
   logic [1:0]           off_q, off_d;
   logic [LEN_W:0]       rem_q, rem_d;
   logic [DIN_WIDTH-1:0] out_data_q, out_data_d;
   logic [1:0]           out_sbcnt_q, out_sbcnt_d;
   logic [DIN_BCNT-1:0]  out_bcnt_q, out_bcnt_d;
   logic                 out_eop_q, out_eop_d;
   logic                 out_vld_q, out_vld_d;
   logic                 err_zero_q, err_zero_d;
`ifdef BEAT_GEN_STRAY_CHK_EN
   logic                 stray_q, stray_d;
`endif

   logic                 out_free;
   logic                 rd_rdy_w;
   logic [LEN_W:0]       cap_w;
   logic [LEN_W:0]       bcnt_w;

   // Output register frees this cycle if empty or being drained by the shifter.
   assign out_free = !out_vld_q || bus.out_rdy;

`ifdef BEAT_GEN_STRAY_CHK_EN
   assign rd_rdy_w = (state_q == S_IDLE) ? 1'b1 : out_free;
`else
   assign rd_rdy_w = (state_q != S_IDLE) && out_free;
`endif

   assign cap_w  = (state_q == S_FIRST) ? (BYTES_W - {{(LEN_W-1){1'b0}}, off_q}) : BYTES_W;
   assign bcnt_w = (cap_w < rem_q) ? cap_w : rem_q;

   always_comb begin
      state_d     = state_q;
      off_d       = off_q;
      rem_d       = rem_q;
      out_data_d  = out_data_q;
      out_sbcnt_d = out_sbcnt_q;
      out_bcnt_d  = out_bcnt_q;
      out_eop_d   = out_eop_q;
      out_vld_d   = out_vld_q;
      err_zero_d  = 1'b0;
`ifdef BEAT_GEN_STRAY_CHK_EN
      stray_d     = stray_q;
`endif

      if (out_vld_q && bus.out_rdy) begin
         out_vld_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (bus.desc_vld) begin
               if (bus.desc_len == '0) begin
                  err_zero_d = 1'b1;
               end else begin
                  off_d   = bus.desc_off;
                  rem_d   = {1'b0, bus.desc_len};
                  state_d = S_FIRST;
               end
            end
`ifdef BEAT_GEN_STRAY_CHK_EN
            if (bus.rd_vld) begin
               stray_d = 1'b1;
            end
`endif
         end
         S_FIRST, S_BODY: begin
            if (bus.rd_vld && rd_rdy_w) begin
               out_data_d  = bus.rd_data;
               out_sbcnt_d = (state_q == S_FIRST) ? off_q : 2'd0;
               out_bcnt_d  = bcnt_w[DIN_BCNT-1:0];
               out_eop_d   = (rem_q == bcnt_w);
               out_vld_d   = 1'b1;
               rem_d       = rem_q - bcnt_w;
               state_d     = (rem_q == bcnt_w) ? S_IDLE : S_BODY;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         off_q       <= '0;
         rem_q       <= '0;
         out_data_q  <= '0;
         out_sbcnt_q <= '0;
         out_bcnt_q  <= '0;
         out_eop_q   <= 1'b0;
         out_vld_q   <= 1'b0;
         err_zero_q  <= 1'b0;
`ifdef BEAT_GEN_STRAY_CHK_EN
         stray_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         off_q       <= off_d;
         rem_q       <= rem_d;
         out_data_q  <= out_data_d;
         out_sbcnt_q <= out_sbcnt_d;
         out_bcnt_q  <= out_bcnt_d;
         out_eop_q   <= out_eop_d;
         out_vld_q   <= out_vld_d;
         err_zero_q  <= err_zero_d;
`ifdef BEAT_GEN_STRAY_CHK_EN
         stray_q     <= stray_d;
`endif
      end
   end

   assign bus.desc_rdy      = (state_q == S_IDLE);
   assign bus.rd_rdy        = rd_rdy_w;
   assign bus.out_data      = out_data_q;
   assign bus.out_sbcnt_hdr = out_sbcnt_q;
   assign bus.out_bcnt      = out_bcnt_q;
   assign bus.out_eop       = out_eop_q;
   assign bus.out_vld       = out_vld_q;
   assign err_zero_len      = err_zero_q;
`ifdef BEAT_GEN_STRAY_CHK_EN
   assign err_stray_beat    = stray_q;
`endif

endmodule
